seq_scan_ctrl: RTL and testbench

//  Frame-level controller for serial pattern detection.
//  - Accepts parallel words over a valid/ready handshake.
//  - Serialises each word LSB-first, one bit per clock.
//  - Matches the bit stream against a runtime-programmed pattern of up to PAT_MAX bits.
//  - Counts hits per frame.
//  - Sits between a word-wide producer (shift/capture logic) and status/interrupt logic.

---
 rtl/seq_scan_pkg.sv | 29 ++
 rtl/seq_scan_ctrl_if.sv | 19 +
 rtl/seq_match_core.sv | 84 ++++++++
 rtl/seq_scan_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared definitions for the serial pattern scanner.
//  - Default sizing for word width, pattern length, length field and hit counter.
//  - Controller FSM state encoding.
//  - clamp_len(): limits a programmed pattern length to the matcher depth.
package seq_scan_pkg;

  localparam int W_DEF       = 16;
  localparam int PAT_MAX_DEF = 8;
  localparam int LW_DEF      = 4;
  localparam int CW_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Lengths above the matcher depth behave as a full-depth pattern.
  function automatic int clamp_len(input int len, input int pat_max);
    int r;
    if (len > pat_max) begin
      r = pat_max;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: word-wide valid/ready handshake feeding the scanner.
//  in_valid  producer -> scanner  word available
//  in_ready  scanner  -> producer scanner can take a word
//  in_data   producer -> scanner  W-bit word, bit 0 serialised first
//  in_last   producer -> scanner  word is the last of its frame
// Modports: master (producer side), slave (scanner side).
interface seq_scan_ctrl_if import seq_scan_pkg::*; #(
  parameter int W = W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: bit-serial pattern matcher.
//  clk        clock, rising edge
//  res        synchronous active-high reset
//  bit_in     serial bit
//  bit_valid  bit_in is valid this cycle
//  pattern    pattern, bit len-1 = first-arriving bit
//  len        already-clamped pattern length, 0 disables matching
//  clear      drop history/seen at the start of a frame
//  hit        registered pulse, one cycle after the completing bit
// Build option SEQ_SCAN_OVERLAP_EN: when defined, history and seen keep running
// after a hit (overlapping matches); otherwise both are cleared on a hit.
module seq_match_core import seq_scan_pkg::*; #(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LW      = LW_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic               clear,
  output logic               hit
);

  logic [PAT_MAX-1:0] hist_r;
  logic [LW-1:0]      seen_r;
  logic               hit_r;
  logic [PAT_MAX-1:0] hist_next_s;
  logic [LW-1:0]      seen_next_s;
  logic [PAT_MAX-1:0] mask_s;
  logic               match_s;

  // Next history/seen and the masked compare against the post-shift history.
  always_comb begin
    hist_next_s = {hist_r[PAT_MAX-2:0], bit_in};
    seen_next_s = seen_r;
    mask_s      = '0;
    match_s     = 1'b0;
    if (seen_r == LW'(PAT_MAX)) begin
      seen_next_s = seen_r;
    end else begin
      seen_next_s = seen_r + LW'(1);
    end
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (i < int'(len));
    end
    if ((len != '0) && (seen_next_s >= len) &&
        ((hist_next_s & mask_s) == (pattern & mask_s))) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // History shift register, saturating seen counter and hit flop.
  always_ff @(posedge clk) begin
    if (res || clear) begin
      hist_r <= '0;
      seen_r <= '0;
      hit_r  <= 1'b0;
    end else if (bit_valid) begin
      hit_r <= match_s;
`ifdef SEQ_SCAN_OVERLAP_EN
      hist_r <= hist_next_s;
      seen_r <= seen_next_s;
`else
      // A completed match consumes its bits.
      if (match_s) begin
        hist_r <= '0;
        seen_r <= '0;
      end else begin
        hist_r <= hist_next_s;
        seen_r <= seen_next_s;
      end
`endif
    end else begin
      hit_r <= 1'b0;
    end
  end

  assign hit = hit_r;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame-level controller for serial pattern detection.
// Takes W-bit words over a valid/ready handshake, serialises them LSB-first
// one bit per clock, matches the stream against a runtime pattern and counts
// hits per frame.
//  clk          clock, rising edge
//  res          synchronous active-high reset
//  cfg_we       load cfg_pattern/cfg_len (honoured only in IDLE)
//  cfg_pattern  pattern, bit len-1 = first-arriving bit
//  cfg_len      pattern length, 0 = off, >PAT_MAX clamps to PAT_MAX
//  bus          word handshake (slave modport of seq_scan_ctrl_if)
//  bit_out      current serial bit;  bit_valid  bit_out valid
//  hit          one-cycle pulse, pattern completed by previous bit
//  match_cnt    hits in the current frame, saturating
//  busy         shifting a word of the frame
//  done         one-cycle pulse after the final bit of the frame
// Build option SEQ_SCAN_OVERLAP_EN selects overlapping matches (see seq_match_core).
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter int W       = W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LW      = LW_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  seq_scan_ctrl_if.slave     bus,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               hit,
  output logic [CW-1:0]      match_cnt,
  output logic               busy,
  output logic               done
);

  localparam int BCW = $clog2(W);

  state_t             state_r;
  logic [W-1:0]       word_r;
  logic               last_r;
  logic [BCW-1:0]     bitcnt_r;
  logic               frame_open_r;
  logic [PAT_MAX-1:0] pattern_r;
  logic [LW-1:0]      len_r;
  logic               in_ready_r;
  logic               bit_out_r;
  logic               bit_valid_r;
  logic               busy_r;
  logic               done_r;
  logic [CW-1:0]      match_cnt_r;
  logic               accept_s;
  logic               clear_s;
  logic               hit_s;

  // Handshake acceptance and frame-start detection.
  always_comb begin
    accept_s = 1'b0;
    clear_s  = 1'b0;
    if (bus.in_valid && in_ready_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s && (state_r == ST_IDLE) && !frame_open_r) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  // Controller FSM with word latch, bit counter, config and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r      <= ST_IDLE;
      word_r       <= '0;
      last_r       <= 1'b0;
      bitcnt_r     <= '0;
      frame_open_r <= 1'b0;
      pattern_r    <= '0;
      len_r        <= '0;
      in_ready_r   <= 1'b0;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          // A config written together with a word applies to that word,
          // since its first bit reaches the matcher a cycle later.
          if (cfg_we) begin
            pattern_r <= cfg_pattern;
            len_r     <= LW'(clamp_len(int'(cfg_len), PAT_MAX));
          end
          if (accept_s) begin
            word_r       <= bus.in_data;
            last_r       <= bus.in_last;
            bitcnt_r     <= '0;
            bit_out_r    <= bus.in_data[0];
            bit_valid_r  <= 1'b1;
            busy_r       <= 1'b1;
            in_ready_r   <= 1'b0;
            frame_open_r <= 1'b1;
            state_r      <= ST_SHIFT;
          end else begin
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bitcnt_r == BCW'(W - 1)) begin
            if (last_r) begin
              state_r      <= ST_DONE;
              done_r       <= 1'b1;
              busy_r       <= 1'b0;
              bit_out_r    <= 1'b0;
              bit_valid_r  <= 1'b0;
              in_ready_r   <= 1'b0;
              frame_open_r <= 1'b0;
            end else if (accept_s) begin
              // Gapless: next word's bit 0 follows directly.
              word_r     <= bus.in_data;
              last_r     <= bus.in_last;
              bitcnt_r   <= '0;
              bit_out_r  <= bus.in_data[0];
              in_ready_r <= 1'b0;
            end else begin
              // Producer ran dry: frame stays open, matcher keeps its history.
              state_r     <= ST_IDLE;
              bit_out_r   <= 1'b0;
              bit_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
            end
          end else begin
            bitcnt_r   <= bitcnt_r + BCW'(1);
            bit_out_r  <= word_r[bitcnt_r + BCW'(1)];
            // Ready is offered only while the final bit of a non-last word is out.
            in_ready_r <= (bitcnt_r == BCW'(W - 2)) && !last_r;
          end
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          bit_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Per-frame hit counter, cleared at frame start, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (res || clear_s) begin
      match_cnt_r <= '0;
    end else if (hit_s && (match_cnt_r != {CW{1'b1}})) begin
      match_cnt_r <= match_cnt_r + CW'(1);
    end else begin
      match_cnt_r <= match_cnt_r;
    end
  end

  seq_match_core #(
    .PAT_MAX (PAT_MAX),
    .LW      (LW)
  ) u_match (
    .clk       (clk),
    .res       (res),
    .bit_in    (bit_out_r),
    .bit_valid (bit_valid_r),
    .pattern   (pattern_r),
    .len       (len_r),
    .clear     (clear_s),
    .hit       (hit_s)
  );

  assign bus.in_ready = in_ready_r;
  assign bit_out      = bit_out_r;
  assign bit_valid    = bit_valid_r;
  assign hit          = hit_s;
  assign match_cnt    = match_cnt_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed scoreboard bench for seq_scan_ctrl.
// Each accepted word pushes its 16 expected bits (with expected hit, in_ready
// and done flags from a bit-level reference matcher) into a queue; a monitor
// pops and compares them as the DUT serialises.
module tb_seq_scan_ctrl;

  localparam int W       = 16;
  localparam int PAT_MAX = 8;
  localparam int LW      = 4;
  localparam int CW      = 8;

  logic         clk = 1'b0;
  logic         res;
  logic         cfg_we;
  logic [7:0]   cfg_pattern;
  logic [3:0]   cfg_len;
  logic         bit_out, bit_valid, hit, busy, done;
  logic [7:0]   match_cnt;

  seq_scan_ctrl_if #(.W(W)) bus_if ();

  seq_scan_ctrl #(.W(W), .PAT_MAX(PAT_MAX), .LW(LW), .CW(CW)) dut (
    .clk         (clk),
    .res         (res),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .bus         (bus_if),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .hit         (hit),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic h;
    logic rdy;
    logic dn;
  } exp_t;

  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  int   hit_total = 0;
  int   run = 0;
  int   last_run = 0;
  logic pend_hit = 1'b0;
  logic pend_done = 1'b0;
  bit   mon_en = 1'b0;

  // reference matcher state
  logic [7:0] m_hist = 8'h00;
  logic [7:0] m_pat = 8'h00;
  int         m_seen = 0;
  int         m_len = 0;
  int         m_cnt = 0;
  bit         m_open = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function void push_word(input logic [15:0] d, input logic last);
    exp_t       e;
    logic [7:0] mask;
    if (!m_open) begin
      m_hist = 8'h00;
      m_seen = 0;
      m_cnt  = 0;
      m_open = 1'b1;
    end
    mask = 8'((1 << m_len) - 1);
    for (int k = 0; k < 16; k++) begin
      e.b    = d[k];
      m_hist = {m_hist[6:0], d[k]};
      if (m_seen < 8) m_seen++;
      e.h = (m_len != 0) && (m_seen >= m_len) && ((m_hist & mask) == (m_pat & mask));
      if (e.h) begin
        if (m_cnt < 255) m_cnt++;
`ifndef SEQ_SCAN_OVERLAP_EN
        m_hist = 8'h00;
        m_seen = 0;
`endif
      end
      e.rdy = (k == 15) && !last;
      e.dn  = (k == 15) && last;
      sb.push_back(e);
    end
    if (last) m_open = 1'b0;
  endfunction

  // Monitor: per-cycle bit/ready checks and one-cycle-delayed hit/done checks.
  always @(negedge clk) begin
    if (mon_en && !res) begin
      check("hit", hit, pend_hit);
      check("done", done, pend_done);
      if (hit === 1'b1) hit_total++;
      if (bit_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_bit: got bit_valid=1 expected empty stream");
          pend_hit  = 1'b0;
          pend_done = 1'b0;
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bit_out", bit_out, e.b);
          check("in_ready_stream", bus_if.in_ready, e.rdy);
          pend_hit  = e.h;
          pend_done = e.dn;
        end
        run++;
      end else begin
        pend_hit  = 1'b0;
        pend_done = 1'b0;
        if (run != 0) last_run = run;
        run = 0;
      end
    end else begin
      pend_hit  = 1'b0;
      pend_done = 1'b0;
      run       = 0;
    end
  end

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    m_pat       = pat;
    m_len       = (len > 4'd8) ? 8 : int'(len);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_last  = last;
    while (bus_if.in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus_if.in_ready, 1);
    if (bus_if.in_ready === 1'b1) push_word(d, last);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", done, 1);
    @(negedge clk);
  endtask

  initial begin
    int h0;
    int n;
    bit saw_done;
    res             = 1'b1;
    cfg_we          = 1'b0;
    cfg_pattern     = 8'h00;
    cfg_len         = 4'd0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 16'h0000;
    bus_if.in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", bus_if.in_ready, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match_cnt", match_cnt, 0);
    res = 1'b0;
    @(negedge clk);
    check("idle_ready", bus_if.in_ready, 1);
    mon_en = 1'b1;

    // basic hit count, done latency
    set_cfg(8'b0001_0011, 4'd5);
    h0 = hit_total;
    send_word(16'b1001_1100_1111_0011, 1'b1);
    bus_if.in_valid = 1'b0;
    check("t1_busy", busy, 1);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t1_done_latency", n, 17);
    @(negedge clk);
    check("t1_hits", hit_total - h0, 2);
    check("t1_match_cnt", match_cnt, 2);
    check("t1_busy_after", busy, 0);

    // cfg_we during SHIFT is ignored
    h0 = hit_total;
    send_word(16'b1001_1100_1111_0011, 1'b1);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = 8'hFF;
    cfg_len     = 4'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_done();
    check("cfg_guard_hits", hit_total - h0, 2);
    check("cfg_guard_cnt", match_cnt, 2);

    // len = 0 disables detection
    set_cfg(8'h00, 4'd0);
    h0 = hit_total;
    send_word(16'h0000, 1'b0);
    send_word(16'hFFFF, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("len0_hits", hit_total - h0, 0);
    check("len0_cnt", match_cnt, 0);

    // len = 12 behaves as len = 8
    set_cfg(8'hA5, 4'd12);
    h0 = hit_total;
    send_word(16'h00A5, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("len12_hits", hit_total - h0, 1);
    check("len12_cnt", match_cnt, 1);

    // overlap; config written in the same cycle as the word
    cfg_we      = 1'b1;
    cfg_pattern = 8'b0001_0011;
    cfg_len     = 4'd5;
    m_pat       = 8'b0001_0011;
    m_len       = 5;
    h0 = hit_total;
    send_word(16'h0199, 1'b1);
    cfg_we          = 1'b0;
    bus_if.in_valid = 1'b0;
    wait_done();
`ifdef SEQ_SCAN_OVERLAP_EN
    check("overlap_hits", hit_total - h0, 2);
    check("overlap_cnt", match_cnt, 2);
`else
    check("overlap_hits", hit_total - h0, 1);
    check("overlap_cnt", match_cnt, 1);
`endif

    // gapless streaming with a pattern across the word boundary
    h0 = hit_total;
    send_word(16'h2000, 1'b0);
    send_word(16'h0003, 1'b0);
    send_word(16'h0000, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("stream_run", last_run, 48);
    check("stream_hits", hit_total - h0, 1);
    check("stream_cnt", match_cnt, 1);

    // saturation: 19 all-ones words with len=1 give 304 hits
    set_cfg(8'h01, 4'd1);
    h0 = hit_total;
    for (int i = 0; i < 19; i++) begin
      send_word(16'hFFFF, (i == 18));
    end
    bus_if.in_valid = 1'b0;
    wait_done();
    check("sat_hits", hit_total - h0, 304);
    check("sat_cnt", match_cnt, 255);
    check("sat_cnt_model", match_cnt, m_cnt);

    // frame with a gap: history and count survive
    set_cfg(8'b0001_0011, 4'd5);
    h0 = hit_total;
    send_word(16'h2019, 1'b0);
    bus_if.in_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("gap_cnt_held", match_cnt, 1);
    check("gap_ready", bus_if.in_ready, 1);
    send_word(16'h0003, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("gap_hits", hit_total - h0, 2);
    check("gap_cnt", match_cnt, 2);

    // reset in the middle of SHIFT
    send_word(16'h0199, 1'b1);
    bus_if.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_cnt", match_cnt, 1);
    mon_en = 1'b0;
    res    = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", bus_if.in_ready, 0);
    check("mid_rst_bit_out", bit_out, 0);
    check("mid_rst_bit_valid", bit_valid, 0);
    check("mid_rst_hit", hit, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cnt", match_cnt, 0);
    res = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("mid_rst_no_done", saw_done, 0);
    check("mid_rst_idle_ready", bus_if.in_ready, 1);
    sb.delete();
    m_pat  = 8'h00;
    m_len  = 0;
    m_hist = 8'h00;
    m_seen = 0;
    m_cnt  = 0;
    m_open = 1'b0;
    mon_en = 1'b1;

    // config cleared by reset: no hits
    h0 = hit_total;
    send_word(16'hFFFF, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("post_rst_hits", hit_total - h0, 0);

    // recovery
    set_cfg(8'b0001_0011, 4'd5);
    h0 = hit_total;
    send_word(16'b1001_1100_1111_0011, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_done();
    check("recover_hits", hit_total - h0, 2);
    check("recover_cnt", match_cnt, 2);
    check("sb_drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
